pulse_cmd_decoder: RTL and testbench
====================================

# pulse_cmd_decoder

Receive-side decoder for the single-wire pulse-width command line driven by the team's pulse generator. The generator encodes command 1 as a high pulse of W1 clocks and command 2 as a high pulse of W2 clocks. This block measures each high pulse on `din` and emits a one-cycle strobe for the recovered command, or an error strobe with a cause code. It keeps saturating statistics counters and sits at the far end of the command wire, in the same clock domain or behind its optional synchronizer.

## Interface
- `SYNC_STAGES`, 2, input synchronizer depth on `din`; legal values 0 (same domain, no flops) or 2
- `W1`, 3, pulse width in clocks that encodes command 1
- `W2`, 2, pulse width in clocks that encodes command 2; W1 != W2, both >= 1
- `MAX_W`, 7, width at which a still-high line is declared stuck; must exceed max(W1, W2) + 1
- `CNT_W`, 8, width of each statistics counter
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `din`  in  1  encoded pulse line
- `clr`  in  1  synchronous clear of all three statistics counters
- `cmd1_vld`  out  1  one-cycle strobe: a W1-wide pulse was received
- `cmd2_vld`  out  1  one-cycle strobe: a W2-wide pulse was received
- `err`  out  1  one-cycle strobe: a malformed pulse was received
- `err_code`  out  2  cause, valid only while `err`=1: 01 short, 10 long, 11 stuck
- `cmd1_cnt`, `cmd2_cnt`, `err_cnt`  out  CNT_W each  saturating event counters

## Operation
- `ds` is the decoded sample: `din` after SYNC_STAGES flops, or `din` itself when SYNC_STAGES=0. Synchronizer flops reset to 1.
- Width counter `wid` has width clog2(MAX_W+1) and saturates at MAX_W.
- FSM states are IDLE, HIGH and WAIT_LOW. The reset state is WAIT_LOW.
- WAIT_LOW: on `ds`=0, go to IDLE. This prevents decoding a pulse that was already in flight at reset or after a stuck error.
- IDLE: on `ds`=1, set `wid`<=1 and go to HIGH.
- HIGH with `ds`=1:
  - `wid`<=`wid`+1.
  - If `wid`+1 reaches MAX_W: register `err`=1 and `err_code`=11, then go to WAIT_LOW.
- HIGH with `ds`=0: classify `wid`, then go to IDLE.
  - `wid`==W1: `cmd1_vld`.
  - `wid`==W2: `cmd2_vld`.
  - `wid`<min(W1,W2), or any other width below max(W1,W2): `err`, `err_code`=01.
  - `wid`>max(W1,W2): `err`, `err_code`=10.
- Each low-sampled cycle in HIGH produces exactly one strobe.
- A pulse needs at least one low cycle between pulses. Two pulses with no low cycle between them are measured as one pulse, which is then classified long or stuck.
- Counters:
  - `cmd1_cnt`, `cmd2_cnt` and `err_cnt` increment in the same cycle their strobe is registered.
  - Each counter holds at all-ones (2^CNT_W-1).
  - `clr` zeroes all three counters and has priority over a simultaneous increment; that event is not counted.
- Reset values:
  - `cmd1_vld`, `cmd2_vld` and `err` are 0.
  - `err_code` is 00.
  - All counters are 0.
  - `wid` is 0.
  - FSM is in WAIT_LOW.
  - Reset mid-pulse discards the partial measurement.

## Timing
- Strobes and counters are registered.
- SYNC_STAGES=0:
  - `din` high sampled on edges k..k+n-1 and low on edge k+n.
  - The strobe is high for the single cycle after edge k+n.
  - Decode latency is 1 clock after the first low sample.
- SYNC_STAGES=2: add 2 clocks to all latencies.
- Stuck: the strobe is registered on the edge where `ds` has been sampled high MAX_W consecutive times. Nothing more is reported until `ds` returns low and then goes high again.
- At most one of `cmd1_vld`, `cmd2_vld` or `err` is high in any cycle.
- Minimum sustained throughput is one command per max(W1,W2)+1 clocks.

## Test plan
- Defaults, SYNC_STAGES=0: `din` high 3 cycles, low 1, high 2, low 1.
  - Required: `cmd1_vld` 1 cycle after the first low sample, then `cmd2_vld` 1 cycle after the second.
  - Required: `cmd1_cnt`=1, `cmd2_cnt`=1, `err` never asserted.
- Glitch and long pulses:
  - High 1 cycle -> `err`, `err_code`=01.
  - High 5 cycles -> `err`, `err_code`=10.
  - `err_cnt`=2 afterwards.
- Stuck line: `din` held high 20 cycles.
  - Required: exactly one `err` with `err_code`=11, asserted in the cycle after the 7th high sample.
  - Required: a following 2-cycle pulse, after at least one low cycle, decodes as `cmd2_vld`.
- Reset mid-pulse: `rst_n` low for 1 cycle during the 2nd high cycle of a 3-cycle pulse.
  - Required: no strobe for that pulse.
  - Required: the next clean 3-cycle pulse yields `cmd1_vld`.
  - Required: all outputs are 0 in the cycle after reset.
- Saturation and clear, CNT_W=2:
  - Send 5 command-1 pulses -> `cmd1_cnt` holds at 3.
  - Assert `clr` in the same cycle as a `cmd2_vld` strobe -> all counters 0 next cycle, `cmd2_cnt` stays 0.
- SYNC_STAGES=2: repeat the first scenario; strobes appear exactly 2 clocks later than with SYNC_STAGES=0.

Source files
------------

// File: rtl/pulse_cmd_decoder.sv
// pulse_cmd_decoder
//
// Receive-side decoder for the single-wire pulse-width command line. Each high
// pulse on din is measured in clocks. A pulse W1 clocks wide is reported as
// command 1 and a pulse W2 clocks wide as command 2. Any other width produces
// an error strobe with a cause code. A line that stays high for MAX_W samples
// is reported once as stuck. Three saturating counters keep event statistics.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   din       encoded pulse line (optionally synchronized, SYNC_STAGES = 0 or 2)
//   clr       synchronous clear of all statistics counters; wins over increments
//   cmd1_vld  one-cycle strobe, W1-wide pulse received
//   cmd2_vld  one-cycle strobe, W2-wide pulse received
//   err       one-cycle strobe, malformed pulse received
//   err_code  cause while err=1: 01 short, 10 long, 11 stuck
//   cmd1_cnt  saturating count of cmd1_vld strobes
//   cmd2_cnt  saturating count of cmd2_vld strobes
//   err_cnt   saturating count of err strobes
module pulse_cmd_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int W1          = 3,
    parameter int W2          = 2,
    parameter int MAX_W       = 7,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr,
    output logic             cmd1_vld,
    output logic             cmd2_vld,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cmd1_cnt,
    output logic [CNT_W-1:0] cmd2_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int WID_W = $clog2(MAX_W + 1);
    localparam int W_MAX = (W1 > W2) ? W1 : W2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    // Decoded sample of the line.
    logic ds;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign ds = din;
        end else begin : g_sync
            // Reset to 1 so the FSM, which starts in WAIT_LOW, waits for the
            // real line to be seen low before it accepts a pulse.
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= din;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign ds = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WID_W-1:0] wid_q, wid_d, wid_inc;
    logic             cmd1_d, cmd2_d, err_d;
    logic [1:0]       err_code_d;

    assign wid_inc = wid_q + WID_W'(1);

    always_comb begin
        state_d    = state_q;
        wid_d      = wid_q;
        cmd1_d     = 1'b0;
        cmd2_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = 2'b00;
        case (state_q)
            WAIT_LOW: begin
                if (!ds) state_d = IDLE;
            end
            IDLE: begin
                if (ds) begin
                    wid_d   = WID_W'(1);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (ds) begin
                    wid_d = wid_inc;
                    // MAX_W consecutive high samples: report once, then ignore
                    // the line until it has been seen low again.
                    if (wid_inc == WID_W'(MAX_W)) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b11;
                        state_d    = WAIT_LOW;
                    end
                end else begin
                    state_d = IDLE;
                    if (wid_q == WID_W'(W1)) begin
                        cmd1_d = 1'b1;
                    end else if (wid_q == WID_W'(W2)) begin
                        cmd2_d = 1'b1;
                    end else if (wid_q > WID_W'(W_MAX)) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end else begin
                        // Every non-matching width below the longest code.
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOW;
            wid_q    <= '0;
            cmd1_vld <= 1'b0;
            cmd2_vld <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state_q  <= state_d;
            wid_q    <= wid_d;
            cmd1_vld <= cmd1_d;
            cmd2_vld <= cmd2_d;
            err      <= err_d;
            err_code <= err_code_d;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                  input logic             inc);
        return (inc && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    // Counters step on the same edge that registers the strobe.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cmd1_cnt <= '0;
            cmd2_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            cmd1_cnt <= sat_inc(cmd1_cnt, cmd1_d);
            cmd2_cnt <= sat_inc(cmd2_cnt, cmd2_d);
            err_cnt  <= sat_inc(err_cnt, err_d);
        end
    end

endmodule

// File: tb/tb_pulse_cmd_decoder.sv
// Bench for pulse_cmd_decoder. Three instances share the stimulus:
//   d0 : SYNC_STAGES=0, CNT_W=8
//   ds : SYNC_STAGES=2, CNT_W=8 (strobes two clocks after d0)
//   dc : SYNC_STAGES=0, CNT_W=2 (saturation)
module tb_pulse_cmd_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic din   = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    logic       d0_c1v, d0_c2v, d0_err;
    logic [1:0] d0_code;
    logic [7:0] d0_c1, d0_c2, d0_e;
    logic       ds_c1v, ds_c2v, ds_err;
    logic [1:0] ds_code;
    logic [7:0] ds_c1, ds_c2, ds_e;
    logic       dc_c1v, dc_c2v, dc_err;
    logic [1:0] dc_code;
    logic [1:0] dc_c1, dc_c2, dc_e;

    logic [2:0] d0_stb, ds_stb, dc_stb;
    assign d0_stb = {d0_c1v, d0_c2v, d0_err};
    assign ds_stb = {ds_c1v, ds_c2v, ds_err};
    assign dc_stb = {dc_c1v, dc_c2v, dc_err};

    pulse_cmd_decoder #(.SYNC_STAGES(0), .W1(3), .W2(2), .MAX_W(7), .CNT_W(8)) d0 (
        .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
        .cmd1_vld(d0_c1v), .cmd2_vld(d0_c2v), .err(d0_err), .err_code(d0_code),
        .cmd1_cnt(d0_c1), .cmd2_cnt(d0_c2), .err_cnt(d0_e)
    );

    pulse_cmd_decoder #(.SYNC_STAGES(2), .W1(3), .W2(2), .MAX_W(7), .CNT_W(8)) ds (
        .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
        .cmd1_vld(ds_c1v), .cmd2_vld(ds_c2v), .err(ds_err), .err_code(ds_code),
        .cmd1_cnt(ds_c1), .cmd2_cnt(ds_c2), .err_cnt(ds_e)
    );

    pulse_cmd_decoder #(.SYNC_STAGES(0), .W1(3), .W2(2), .MAX_W(7), .CNT_W(2)) dc (
        .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
        .cmd1_vld(dc_c1v), .cmd2_vld(dc_c2v), .err(dc_err), .err_code(dc_code),
        .cmd1_cnt(dc_c1), .cmd2_cnt(dc_c2), .err_cnt(dc_e)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive din for one clock; return 1ns after the edge that sampled it.
    task automatic send(input logic d);
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        clr   = 1'b0;
        din   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check({tag, "_stb"},  {23'd0, d0_stb, ds_stb, dc_stb}, 32'd0);
        check({tag, "_code"}, {26'd0, d0_code, ds_code, dc_code}, 32'd0);
        check({tag, "_cnt0"}, {8'd0, d0_c1, d0_c2, d0_e}, 32'd0);
        check({tag, "_cnts"}, {8'd0, ds_c1, ds_c2, ds_e}, 32'd0);
        check({tag, "_cntc"}, {26'd0, dc_c1, dc_c2, dc_e}, 32'd0);
        rst_n = 1'b1;
        idle(4);
    endtask

    // First scenario: high 3, low 1, high 2, low 4. Expected strobes
    // {cmd1,cmd2,err} per sampled cycle for d0 and for the synchronized ds.
    logic       s1_din [10] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
    logic [2:0] s1_e0  [10] = '{0, 0, 0, 4, 0, 0, 2, 0, 0, 0};
    logic [2:0] s1_es  [10] = '{0, 0, 0, 0, 0, 4, 0, 0, 2, 0};

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset("rst");

        // Back-to-back cmd1 / cmd2.
        for (int i = 0; i < 10; i++) begin
            send(s1_din[i]);
            check($sformatf("s1_d0_%0d", i), {29'd0, d0_stb}, {29'd0, s1_e0[i]});
            check($sformatf("s1_ds_%0d", i), {29'd0, ds_stb}, {29'd0, s1_es[i]});
        end
        check("s1_cnt_d0", {8'd0, d0_c1, d0_c2, d0_e}, {8'd0, 8'd1, 8'd1, 8'd0});
        check("s1_cnt_ds", {8'd0, ds_c1, ds_c2, ds_e}, {8'd0, 8'd1, 8'd1, 8'd0});

        // Glitch (1 clock) and long (5 clocks) pulses.
        send(1'b1);
        send(1'b0);
        check("glitch", {29'd0, d0_err, d0_code}, 32'b101);
        idle(3);
        for (int i = 0; i < 5; i++) send(1'b1);
        send(1'b0);
        check("long", {29'd0, d0_err, d0_code}, 32'b110);
        idle(3);
        check("err_cnt_d0", {24'd0, d0_e}, 32'd2);
        check("err_cnt_ds", {24'd0, ds_e}, 32'd2);
        check("err_cnt_dc", {30'd0, dc_e}, 32'd2);

        // Stuck line: exactly one err, on the 7th high sample.
        for (int i = 0; i < 20; i++) begin
            send(1'b1);
            check($sformatf("stuck_err_%0d", i), {31'd0, d0_err}, {31'd0, (i == 6)});
            if (i == 6) check("stuck_code", {30'd0, d0_code}, 32'b11);
        end
        check("stuck_cnt", {24'd0, d0_e}, 32'd3);
        idle(2);
        send(1'b1);
        send(1'b1);
        send(1'b0);
        check("after_stuck", {29'd0, d0_stb}, 32'b010);
        idle(3);

        // Reset during the 2nd high cycle of a 3-cycle pulse.
        send(1'b1);
        rst_n = 1'b0;
        send(1'b1);
        check("midrst_stb",  {29'd0, d0_stb}, 32'd0);
        check("midrst_code", {30'd0, d0_code}, 32'd0);
        check("midrst_cnt",  {8'd0, d0_c1, d0_c2, d0_e}, 32'd0);
        rst_n = 1'b1;
        send(1'b1);
        check("midrst_hi", {29'd0, d0_stb}, 32'd0);
        send(1'b0);
        check("midrst_lo", {29'd0, d0_stb}, 32'd0);
        idle(2);
        check("midrst_idle", {29'd0, d0_stb}, 32'd0);
        send(1'b1);
        send(1'b1);
        send(1'b1);
        send(1'b0);
        check("clean_cmd1", {29'd0, d0_stb}, 32'b100);
        check("clean_cnt",  {24'd0, d0_c1}, 32'd1);
        idle(4);

        // Saturation on the 2-bit counters, then clr against a cmd2 strobe.
        apply_reset("rst2");
        for (int p = 0; p < 5; p++) begin
            send(1'b1);
            send(1'b1);
            send(1'b1);
            send(1'b0);
            check($sformatf("sat_stb_%0d", p), {29'd0, dc_stb}, 32'b100);
            check($sformatf("sat_cnt_%0d", p), {30'd0, dc_c1}, (p < 3) ? p + 1 : 3);
            send(1'b0);
        end
        send(1'b1);
        send(1'b0);
        check("sat_err_cnt", {30'd0, dc_e}, 32'd1);
        idle(1);
        send(1'b1);
        send(1'b1);
        clr = 1'b1;
        send(1'b0);
        clr = 1'b0;
        check("clr_stb",   {29'd0, dc_stb}, 32'b010);
        check("clr_cntc",  {26'd0, dc_c1, dc_c2, dc_e}, 32'd0);
        check("clr_cnt0",  {8'd0, d0_c1, d0_c2, d0_e}, 32'd0);
        send(1'b0);
        check("clr_hold",  {26'd0, dc_c1, dc_c2, dc_e}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
